tty_text_engine: RTL and testbench
==================================

// Module: tty_text_engine
// PURPOSE
//  Parametrised text-mode terminal core for the VGA TTY. Accepts characters over a valid/ready
//  stream, keeps cursor state and a COLS x ROWS character RAM, and scrolls in hardware through a
//  ring-buffer top-row pointer. Page flipping is not used. Serves the scan-out side through a
//  logical (col,row) read port with 1-cycle latency. Sits between the bus write decode and the
//  glyph/char ROM stage.
// PARAMETERS
//  COLS       40        visible text columns
//  ROWS       30        visible text rows
//  TAB_W      4         tab stop spacing, in columns
//  BLINK_DIV  25000000  cycles per cursor blink half-period (used only with CURSOR_BLINK_EN)
//  CW/RW      derived   $clog2(COLS) / $clog2(ROWS); localparams, not overridable
// PORTS
//  clk_50mhz   in   1   single clock; all logic is on the rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  wr_valid    in   1   a character is offered
//  wr_char     in   8   character code
//  wr_ready    out  1   engine can accept; transfer = wr_valid & wr_ready
//  rd_col      in   CW  scan-out logical column
//  rd_row      in   RW  scan-out logical row (0 = top of screen)
//  rd_char     out  8   char at (rd_col,rd_row), registered
//  rd_cursor   out  1   (rd_col,rd_row) is the cursor cell, registered
//  cur_x       out  CW  cursor column
//  cur_y       out  RW  cursor logical row
//  scroll_top  out  RW  physical RAM row displayed as logical row 0
// BEHAVIOUR
//  - Addressing: phys_row = (logical_row + scroll_top) mod ROWS; addr = phys_row*COLS + col.
//    The RAM has COLS*ROWS bytes and is read-first.
//  - States: CLEAR_ALL, IDLE, CLEAR_LINE. wr_ready = (state==IDLE).
//  - Reset: state=CLEAR_ALL, cur_x=0, cur_y=0, scroll_top=0, wr_ready=0, rd_char=0, rd_cursor=0.
//  - CLEAR_ALL writes 0 to one address per cycle, 0..COLS*ROWS-1, then goes to IDLE.
//    It takes exactly COLS*ROWS cycles.
//  - Accepted character, decoded in IDLE:
//    0x0D CR/enter  -> newline.
//    0x08 BS        -> if x>0: x-=1 and write 0 at the new cell.
//                      if x==0 and y>0: x=COLS-1, y-=1, and write 0 at the new cell.
//                      at (0,0): no-op.
//    0x09 TAB       -> x = (x/TAB_W+1)*TAB_W; if the result >= COLS -> newline.
//    0x1B ESC       -> cursor=(0,0), scroll_top=0, go to CLEAR_ALL.
//    other          -> write the char at the cursor, x+=1; if x reaches COLS -> newline.
//  - Newline: x=0. If y<ROWS-1 then y+=1 and stay in IDLE.
//    Else y stays at ROWS-1, scroll_top=(scroll_top+1) mod ROWS, and the engine enters
//    CLEAR_LINE. CLEAR_LINE zeroes the old scroll_top physical row (now the bottom row)
//    over COLS cycles, then returns to IDLE.
//  - The character write and the cursor update happen in the acceptance cycle.
//  - Back-to-back printable chars are accepted every cycle while in IDLE.
//  - wr_valid while wr_ready=0 is held off. Source data must stay stable until accepted.
//  - Read port never stalls. rd_char/rd_cursor reflect the inputs sampled on the previous edge.
//    If rd_col>=COLS or rd_row>=ROWS: rd_char=0 and rd_cursor=0.
//    A same-cycle write to the read address returns the old data.
//    During CLEAR_* reads return the current RAM contents.
//  - rst_n asserted mid-operation: everything resets at once and CLEAR_ALL restarts from addr 0.
// CONFIGURATION
//  CURSOR_BLINK_EN defined:
//    A counter of BLINK_DIV cycles toggles a blink phase. The phase is 1 at reset.
//    rd_cursor = cell match & phase.
//  CURSOR_BLINK_EN undefined:
//    rd_cursor = cell match, steady. No counter or phase logic is synthesised.
// TESTING
//  1 reset, COLS=40 ROWS=30 -> wr_ready=0 for 1200 cycles then 1; every cell reads 0.
//  2 write 'A','B',0x0D,'C' -> (0,0)=0x41, (1,0)=0x42, (0,1)=0x43; cur=(1,1).
//  3 write 41 chars 'x' -> 41st lands at (0,1), cur=(1,1).
//    Then BS x2 -> cur=(39,0), (39,0)=0.
//  4 fill to row 29, then 0x0D -> scroll_top=1, wr_ready low 40 cycles; logical row 29 reads 0.
//    Logical row 0 shows the old row 1.
//  5 TAB at x=2 -> x=4. TAB at x=38 -> newline to (0,y+1). ESC -> cur=(0,0), scroll_top=0, 1200-cycle clear.
//  6 rst_n low during CLEAR_LINE -> outputs go to reset values immediately; full clear reruns.
//    With CURSOR_BLINK_EN: rd_cursor at cur toggles every BLINK_DIV cycles.

Source files
------------

// File: rtl/tty_text_engine.sv
// ============================================================================
// Module      : tty_text_engine
// Description : Text-mode terminal core: character stream in, cursor control,
//               ring-buffer scrolling, registered (col,row) scan-out read port.
//               Optional macro CURSOR_BLINK_EN enables the cursor blink phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tty_text_engine #(
    parameter int COLS      = 40,
    parameter int ROWS      = 30,
    parameter int TAB_W     = 4,
    parameter int BLINK_DIV = 25000000,
    localparam int CW       = $clog2(COLS),
    localparam int RW       = $clog2(ROWS)
) (
    input  logic          clk_50mhz,
    input  logic          rst_n,
    input  logic          wr_valid,
    input  logic [7:0]    wr_char,
    output logic          wr_ready,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [7:0]    rd_char,
    output logic          rd_cursor,
    output logic [CW-1:0] cur_x,
    output logic [RW-1:0] cur_y,
    output logic [RW-1:0] scroll_top
);

    localparam int            c_cells     = COLS * ROWS;
    localparam int            AW          = $clog2(c_cells);
    localparam logic [AW-1:0] c_last_addr = AW'(c_cells - 1);
    localparam logic [CW-1:0] c_last_col  = CW'(COLS - 1);
    localparam logic [RW-1:0] c_last_row  = RW'(ROWS - 1);
    localparam logic [RW:0]   c_rows_ext  = (RW+1)'(ROWS);
    localparam logic [7:0]    c_bs        = 8'h08;
    localparam logic [7:0]    c_tab       = 8'h09;
    localparam logic [7:0]    c_cr        = 8'h0D;
    localparam logic [7:0]    c_esc       = 8'h1B;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL  = 2'd0,
        ST_IDLE       = 2'd1,
        ST_CLEAR_LINE = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_clr_addr;
    logic [CW-1:0] r_clr_col;
    logic [RW-1:0] r_clr_row;
    logic [CW-1:0] r_cur_x;
    logic [RW-1:0] r_cur_y;
    logic [RW-1:0] r_scroll_top;
    logic [7:0]    r_mem [c_cells];

    logic          w_accept;
    logic [31:0]   w_tab;
    logic [CW-1:0] w_nx;
    logic [RW-1:0] w_ny;
    logic          w_nl;
    logic          w_scroll;
    logic          w_esc;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [7:0]    w_wdata;
    logic          w_rd_ok;
    logic [AW-1:0] w_rd_addr;
    logic          w_phase;

    // Logical row to physical RAM row through the ring-buffer top pointer.
    function automatic logic [RW-1:0] f_phys(input logic [RW-1:0] row, input logic [RW-1:0] top);
        logic [RW:0] s;
        s = {1'b0, row} + {1'b0, top};
        if (s >= c_rows_ext)
            s = s - c_rows_ext;
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] f_addr(input logic [RW-1:0] prow, input logic [CW-1:0] col);
        return AW'(prow) * AW'(COLS) + AW'(col);
    endfunction

    assign w_accept   = wr_valid && (r_state == ST_IDLE);
    assign w_tab      = ((32'(r_cur_x) / 32'(TAB_W)) + 32'd1) * 32'(TAB_W);
    assign wr_ready   = (r_state == ST_IDLE);
    assign cur_x      = r_cur_x;
    assign cur_y      = r_cur_y;
    assign scroll_top = r_scroll_top;

    always_comb begin
        w_nx     = r_cur_x;
        w_ny     = r_cur_y;
        w_nl     = 1'b0;
        w_scroll = 1'b0;
        w_esc    = 1'b0;
        w_we     = 1'b0;
        w_waddr  = f_addr(f_phys(r_cur_y, r_scroll_top), r_cur_x);
        w_wdata  = wr_char;
        case (r_state)
            ST_CLEAR_ALL: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = 8'h00;
            end
            ST_CLEAR_LINE: begin
                w_we    = 1'b1;
                w_waddr = f_addr(r_clr_row, r_clr_col);
                w_wdata = 8'h00;
            end
            ST_IDLE: begin
                if (w_accept) begin
                    case (wr_char)
                        c_cr:  w_nl = 1'b1;
                        c_bs: begin
                            if (r_cur_x != '0) begin
                                w_nx    = r_cur_x - 1'b1;
                                w_we    = 1'b1;
                                w_wdata = 8'h00;
                                w_waddr = f_addr(f_phys(r_cur_y, r_scroll_top), r_cur_x - 1'b1);
                            end else if (r_cur_y != '0) begin
                                w_nx    = c_last_col;
                                w_ny    = r_cur_y - 1'b1;
                                w_we    = 1'b1;
                                w_wdata = 8'h00;
                                w_waddr = f_addr(f_phys(r_cur_y - 1'b1, r_scroll_top), c_last_col);
                            end
                        end
                        c_tab: begin
                            if (w_tab >= 32'(COLS))
                                w_nl = 1'b1;
                            else
                                w_nx = CW'(w_tab);
                        end
                        c_esc: begin
                            w_esc = 1'b1;
                            w_nx  = '0;
                            w_ny  = '0;
                        end
                        default: begin
                            w_we = 1'b1;
                            if (r_cur_x == c_last_col)
                                w_nl = 1'b1;
                            else
                                w_nx = r_cur_x + 1'b1;
                        end
                    endcase
                end
            end
            default: ;
        endcase
        // At the bottom row a newline scrolls instead of moving the cursor.
        if (w_nl) begin
            w_nx = '0;
            if (r_cur_y != c_last_row)
                w_ny = r_cur_y + 1'b1;
            else
                w_scroll = 1'b1;
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_CLEAR_ALL;
            r_clr_addr   <= '0;
            r_clr_col    <= '0;
            r_clr_row    <= '0;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_scroll_top <= '0;
        end else begin
            case (r_state)
                ST_CLEAR_ALL: begin
                    if (r_clr_addr == c_last_addr) begin
                        r_clr_addr <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                ST_CLEAR_LINE: begin
                    if (r_clr_col == c_last_col)
                        r_state <= ST_IDLE;
                    else
                        r_clr_col <= r_clr_col + 1'b1;
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cur_x <= w_nx;
                        r_cur_y <= w_ny;
                        if (w_esc) begin
                            r_scroll_top <= '0;
                            r_clr_addr   <= '0;
                            r_state      <= ST_CLEAR_ALL;
                        end else if (w_scroll) begin
                            r_scroll_top <= (r_scroll_top == c_last_row) ? '0 : r_scroll_top + 1'b1;
                            r_clr_row    <= r_scroll_top;
                            r_clr_col    <= '0;
                            r_state      <= ST_CLEAR_LINE;
                        end
                    end
                end
                default: r_state <= ST_CLEAR_ALL;
            endcase
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    assign w_rd_ok   = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);
    assign w_rd_addr = f_addr(f_phys(rd_row, r_scroll_top), rd_col);

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            rd_char   <= 8'h00;
            rd_cursor <= 1'b0;
        end else begin
            rd_char   <= w_rd_ok ? r_mem[w_rd_addr] : 8'h00;
            rd_cursor <= w_rd_ok && (rd_col == r_cur_x) && (rd_row == r_cur_y) && w_phase;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int                   c_blink_w    = $clog2(BLINK_DIV + 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_phase;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == c_blink_last) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    assign w_phase = r_blink_phase;
`else
    assign w_phase = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tty_text_engine.sv
// ============================================================================
// Module      : tb_tty_text_engine
// Description : Self-checking bench for tty_text_engine against a logical
//               screen model (row shifting, no physical addressing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tty_text_engine;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int TAB_W = 4;

    logic       clk_50mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       wr_valid  = 1'b0;
    logic [7:0] wr_char   = 8'h00;
    logic       wr_ready;
    logic [5:0] rd_col    = '0;
    logic [4:0] rd_row    = '0;
    logic [7:0] rd_char;
    logic       rd_cursor;
    logic [5:0] cur_x;
    logic [4:0] cur_y;
    logic [4:0] scroll_top;

    tty_text_engine #(.COLS(COLS), .ROWS(ROWS), .TAB_W(TAB_W)) dut (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_char   (wr_char),
        .wr_ready  (wr_ready),
        .rd_col    (rd_col),
        .rd_row    (rd_row),
        .rd_char   (rd_char),
        .rd_cursor (rd_cursor),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .scroll_top(scroll_top)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    logic [7:0] scr [ROWS][COLS];
    int mx, my, mst;
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mst = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 8'h00;
    endtask

    task automatic model_newline(output int busy);
        busy = 0;
        mx = 0;
        if (my < ROWS - 1) begin
            my++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++)
                    scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++)
                scr[ROWS-1][c] = 8'h00;
            mst = (mst + 1) % ROWS;
            busy = COLS;
        end
    endtask

    // Returns the number of cycles the engine should stay busy afterwards.
    task automatic model_accept(input logic [7:0] c, output int busy);
        int t;
        busy = 0;
        case (c)
            8'h0D: model_newline(busy);
            8'h08: begin
                if (mx > 0) begin
                    mx--; scr[my][mx] = 8'h00;
                end else if (my > 0) begin
                    mx = COLS - 1; my--; scr[my][mx] = 8'h00;
                end
            end
            8'h09: begin
                t = (mx / TAB_W + 1) * TAB_W;
                if (t >= COLS) model_newline(busy);
                else mx = t;
            end
            8'h1B: begin
                model_reset();
                busy = COLS * ROWS;
            end
            default: begin
                scr[my][mx] = c;
                mx++;
                if (mx == COLS) model_newline(busy);
            end
        endcase
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [7:0] c);
        int n;
        int busy;
        wr_char  = c;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 3000) begin
            @(posedge clk_50mhz); #1; n++;
        end
        if (!wr_ready) begin
            chk("ready_timeout", 32'(wr_ready), 32'd1);
            wr_valid = 1'b0;
            return;
        end
        @(posedge clk_50mhz); #1;
        wr_valid = 1'b0;
        model_accept(c, busy);
        chk("cur_x", 32'(cur_x), 32'(mx));
        chk("cur_y", 32'(cur_y), 32'(my));
        chk("scroll_top", 32'(scroll_top), 32'(mst));
        if (busy > 0) begin
            n = 0;
            while (!wr_ready && n < busy + 50) begin
                @(posedge clk_50mhz); #1; n++;
            end
            chk("busy_cycles", 32'(n), 32'(busy));
        end else begin
            chk("ready_after", 32'(wr_ready), 32'd1);
        end
    endtask

    task automatic rd_at(input int col, input int row);
        rd_col = 6'(col);
        rd_row = 5'(row);
        @(posedge clk_50mhz); #1;
    endtask

    task automatic check_cell(input int col, input int row);
        logic [7:0] ec;
        logic       ecur;
        bit         inr;
        inr  = (col < COLS) && (row < ROWS);
        ec   = inr ? scr[row][col] : 8'h00;
        ecur = inr && (col == mx) && (row == my);
        rd_at(col, row);
        chk("rd_char", 32'(rd_char), 32'(ec));
        chk("rd_cursor", 32'(rd_cursor), 32'(ecur));
    endtask

    task automatic scan_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                check_cell(c, r);
    endtask

    task automatic wait_clear_all();
        int n;
        n = 0;
        while (!wr_ready && n < 2000) begin
            @(posedge clk_50mhz); #1; n++;
        end
        chk("clear_all_cycles", 32'(n), 32'(COLS * ROWS));
    endtask

    initial begin
        int esc_cnt;
        int r;
        logic [7:0] ch;

        // Reset values and initial clear
        model_reset();
        rd_col = 6'd3; rd_row = 5'd0;
        @(posedge clk_50mhz); #1;
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_char", 32'(rd_char), 32'd0);
        chk("rst_rd_cursor", 32'(rd_cursor), 32'd0);
        chk("rst_cur", {cur_x, cur_y, scroll_top}, 32'd0);
        rst_n = 1'b1;
        wait_clear_all();
        scan_all();

        // Two characters, newline, one more
        send(8'h41); send(8'h42); send(8'h0D); send(8'h43);
        rd_at(0, 0); chk("cell_0_0", 32'(rd_char), 32'h41);
        rd_at(1, 0); chk("cell_1_0", 32'(rd_char), 32'h42);
        rd_at(0, 1); chk("cell_0_1", 32'(rd_char), 32'h43);
        chk("cur_1_1", {cur_x, cur_y}, {21'd0, 6'd1, 5'd1});

        // Line wrap and backspace across the line boundary
        send(8'h1B);
        for (int i = 0; i < 41; i++) send(8'h78);
        rd_at(0, 1); chk("wrap_cell", 32'(rd_char), 32'h78);
        chk("wrap_cur", {cur_x, cur_y}, {21'd0, 6'd1, 5'd1});
        send(8'h08); send(8'h08);
        chk("bs_cur", {cur_x, cur_y}, {21'd0, 6'd39, 5'd0});
        rd_at(39, 0); chk("bs_cell", 32'(rd_char), 32'h00);
        check_cell(38, 0);

        // Fill every row, then scroll
        send(8'h1B);
        for (int i = 0; i < ROWS; i++) begin
            send(8'h61 + 8'(i));
            if (i < ROWS - 1) send(8'h0D);
        end
        send(8'h0D);
        chk("scroll_top_1", 32'(scroll_top), 32'd1);
        rd_at(0, 0); chk("row0_old_row1", 32'(rd_char), 32'h62);
        rd_at(0, 29); chk("row29_cleared", 32'(rd_char), 32'h00);
        scan_all();

        // Tab stops and ESC
        send(8'h1B);
        send(8'h70); send(8'h71); send(8'h09);
        chk("tab_x4", 32'(cur_x), 32'd4);
        for (int i = 0; i < 34; i++) send(8'h30 + 8'(i % 10));
        chk("x38", 32'(cur_x), 32'd38);
        send(8'h09);
        chk("tab_nl", {cur_x, cur_y}, {21'd0, 6'd0, 5'd1});
        check_cell(37, 0);

        // Out-of-range reads return zero
        rd_at(45, 0); chk("oor_col", {rd_char, rd_cursor}, 32'd0);
        rd_at(0, 31); chk("oor_row", {rd_char, rd_cursor}, 32'd0);

        // Reset while a line clear is in progress
        for (int i = 0; i < 28; i++) send(8'h0D);
        send(8'h5A);
        rd_at(0, 29);
        chk("pre_rst_char", 32'(rd_char), 32'h5A);
        wr_char = 8'h0D; wr_valid = 1'b1;
        @(posedge clk_50mhz); #1;
        wr_valid = 1'b0;
        chk("line_clear_busy", 32'(wr_ready), 32'd0);
        rd_col = 6'd0; rd_row = 5'd28;
        @(posedge clk_50mhz); #1;
        chk("pre_rst_rd", 32'(rd_char), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(wr_ready), 32'd0);
        chk("midrst_rd", {rd_char, rd_cursor}, 32'd0);
        chk("midrst_cur", {cur_x, cur_y, scroll_top}, 32'd0);
        @(posedge clk_50mhz); #1;
        rst_n = 1'b1;
        model_reset();
        wait_clear_all();
        scan_all();

        // Randomised character stream
        esc_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)                         ch = 8'h0D;
            else if (r < 14)                   ch = 8'h08;
            else if (r < 19)                   ch = 8'h09;
            else if (r == 99 && esc_cnt < 2) begin
                ch = 8'h1B; esc_cnt++;
            end else                           ch = 8'($urandom_range(32, 126));
            send(ch);
            if (i % 40 == 39)
                for (int k = 0; k < 8; k++)
                    check_cell($urandom_range(0, COLS - 1), $urandom_range(0, ROWS - 1));
            if (i % 200 == 199) scan_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
